main_controller: RTL and testbench

Top-level controller of the skeletonization engine. It loads an N×N grayscale image one pixel at a time, binarizes it, and thins it to a one-pixel-wide skeleton using Zhang-Suen two-subiteration thinning. It repeats full iterations until an iteration deletes nothing. The result is then held for readback through a single-pixel read port.

---
 rtl/main_controller_if.sv | 26 ++
 rtl/main_controller.sv | 163 ++++++++++++++++
 tb/tb_main_controller.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/main_controller_if.sv
// Pixel load, readback and status bundle of the skeletonization engine.
// The master side loads pixels and reads the result; the slave is the engine.
interface main_controller_if #(
  parameter int N          = 8,
  parameter int pixelWidth = 8
);
  localparam int bitSize = $clog2(N * N);

  logic                  we;
  logic [pixelWidth-1:0] data_in;
  logic [bitSize-1:0]    rd_addr;
  logic                  rd_data;
  logic                  busy;
  logic                  done;
  logic [7:0]            iter_count;

  modport master (
    output we, data_in, rd_addr,
    input  rd_data, busy, done, iter_count
  );

  modport slave (
    input  we, data_in, rd_addr,
    output rd_data, busy, done, iter_count
  );
endinterface

// File: rtl/main_controller.sv
// Skeletonization engine: half-rate image load, binarize, then
// Zhang-Suen thinning until an iteration deletes nothing.
module main_controller #(
  parameter int N = 8
) (
  input logic             clk,
  input logic             rst_n,
  main_controller_if.slave bus
);
  localparam int NN      = N * N;
  localparam int bitSize = $clog2(NN);
  localparam logic [bitSize-1:0] LAST = bitSize'(NN - 1);
  localparam logic [bitSize-1:0] ONE  = bitSize'(1);

  typedef enum logic [2:0] {
    IDLE, LOAD, PASS1, COMMIT1,
    PASS2, COMMIT2, CHECK, DONE
  } state_t;

  state_t             state;
  logic               phase;
  logic [bitSize-1:0] wr_addr;
  logic [bitSize-1:0] scan;
  logic [NN-1:0]      img;
  logic [NN-1:0]      del;
  logic               changed;
  logic               busy;
  logic               done;
  logic [7:0]         iter_count;
  logic               cap;
  logic               pix;
  logic               mark;

  assign cap            = bus.we && phase;
  assign pix            = |bus.data_in;
  assign bus.rd_data    = img[bus.rd_addr];
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.iter_count = iter_count;

  function automatic logic px(
    input logic [NN-1:0] im,
    input int            r,
    input int            c
  );
    logic [bitSize-1:0] i;
    i = bitSize'(r * N + c);
    if (r < 0 || r >= N || c < 0 || c >= N)
      return 1'b0;
    return im[i];
  endfunction

  // nb[0..7] = P2..P9, clockwise from north
  always_comb begin
    int         r;
    int         c;
    logic [7:0] nb;
    logic [3:0] b;
    logic [3:0] a;
    logic       side;
    r     = int'(scan) / N;
    c     = int'(scan) % N;
    nb[0] = px(img, r - 1, c);
    nb[1] = px(img, r - 1, c + 1);
    nb[2] = px(img, r, c + 1);
    nb[3] = px(img, r + 1, c + 1);
    nb[4] = px(img, r + 1, c);
    nb[5] = px(img, r + 1, c - 1);
    nb[6] = px(img, r, c - 1);
    nb[7] = px(img, r - 1, c - 1);
    b = '0;
    a = '0;
    for (int i = 0; i < 8; i++) begin
      b = b + 4'(nb[3'(i)]);
      a = a + 4'(!nb[3'(i)] && nb[3'(i + 1)]);
    end
    if (state == PASS1)
      side = !(nb[0] && nb[2] && nb[4]) &&
             !(nb[2] && nb[4] && nb[6]);
    else
      side = !(nb[0] && nb[2] && nb[6]) &&
             !(nb[0] && nb[4] && nb[6]);
    mark = img[scan] && b >= 4'd2 && b <= 4'd6 &&
           a == 4'd1 && side;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= 1'b0;
      wr_addr    <= '0;
      scan       <= '0;
      img        <= '0;
      del        <= '0;
      changed    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      iter_count <= '0;
    end else begin
      phase <= ~phase;
      unique case (state)
        IDLE: begin
          if (cap) begin
            img[0]  <= pix;
            wr_addr <= ONE;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (cap) begin
            img[wr_addr] <= pix;
            if (wr_addr == LAST) begin
              wr_addr <= '0;
              scan    <= '0;
              busy    <= 1'b1;
              state   <= PASS1;
            end else begin
              wr_addr <= wr_addr + ONE;
            end
          end
        end
        PASS1, PASS2: begin
          del[scan] <= mark;
          if (scan == LAST) begin
            scan  <= '0;
            state <= (state == PASS1) ? COMMIT1 : COMMIT2;
          end else begin
            scan <= scan + ONE;
          end
        end
        COMMIT1, COMMIT2: begin
          img     <= img & ~del;
          del     <= '0;
          changed <= changed | (|del);
          state   <= (state == COMMIT1) ? PASS2 : CHECK;
        end
        CHECK: begin
          if (iter_count != 8'hFF)
            iter_count <= iter_count + 8'd1;
          if (changed) begin
            changed <= 1'b0;
            state   <= PASS1;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (cap) begin
            img[0]     <= pix;
            wr_addr    <= ONE;
            iter_count <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            state      <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_main_controller.sv
// Directed bench for main_controller: loads small images and checks
// timing, iteration count and the thinned result.
module tb_main_controller;
  localparam int N  = 8;
  localparam int NN = N * N;
  localparam int ITER_CYC = 2 * (NN + 1) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  main_controller_if #(.N(N), .pixelWidth(8)) bus();

  main_controller #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] B1 = 64'h1;
  localparam logic [63:0] IM_ZERO = 64'h0;
  localparam logic [63:0] IM_DOT  = B1 << 27;
  localparam logic [63:0] IM_LINE =
    (B1 << 26) | (B1 << 27) | (B1 << 28);
  localparam logic [63:0] IM_SQ2 =
    (B1 << 27) | (B1 << 28) | (B1 << 35) | (B1 << 36);
  localparam logic [63:0] IM_SQ3 =
    (B1 << 18) | (B1 << 19) | (B1 << 20) |
    (B1 << 26) | (B1 << 27) | (B1 << 28) |
    (B1 << 34) | (B1 << 35) | (B1 << 36);

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic read_img(output logic [63:0] v);
    v = '0;
    for (int a = 0; a < NN; a++) begin
      bus.rd_addr = 6'(a);
      #1;
      v[a] = bus.rd_data;
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.we      = 1'b0;
    bus.data_in = '0;
    bus.rd_addr = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // each pixel held two clocks; an even-length pause keeps alignment
  task automatic load(input logic [63:0] im, input int pause_at);
    for (int a = 0; a < NN; a++) begin
      if (a == pause_at) begin
        bus.we = 1'b0;
        repeat (4) @(negedge clk);
      end
      bus.we      = 1'b1;
      bus.data_in = im[a] ? 8'((a * 37) % 255 + 1) : 8'h00;
      @(negedge clk);
      @(negedge clk);
    end
    bus.we      = 1'b0;
    bus.data_in = '0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run(
    input string       name,
    input logic [63:0] im,
    input logic [63:0] exp_img,
    input int          iters,
    input int          pause_at
  );
    int          n;
    logic [63:0] v;
    do_reset();
    load(im, pause_at);
    chk({name, " busy_after_load"}, 64'(bus.busy), 64'd1);
    chk({name, " done_after_load"}, 64'(bus.done), 64'd0);
    wait_done(n);
    chk({name, " cycles"}, 64'(n), 64'(iters * ITER_CYC));
    chk({name, " busy_at_done"}, 64'(bus.busy), 64'd0);
    chk({name, " iter_count"}, 64'(bus.iter_count), 64'(iters));
    read_img(v);
    chk({name, " image"}, v, exp_img);
  endtask

  initial begin
    int          n;
    logic [63:0] v;

    bus.we      = 1'b0;
    bus.data_in = '0;
    bus.rd_addr = 6'd27;
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset iter", 64'(bus.iter_count), 64'd0);
    chk("reset rd", 64'(bus.rd_data), 64'd0);

    run("zero", IM_ZERO, 64'h0, 1, -1);
    run("dot", IM_DOT, IM_DOT, 1, -1);
    run("line", IM_LINE, IM_LINE, 1, 30);
    run("sq2", IM_SQ2, 64'h0, 2, -1);
    run("sq3", IM_SQ3, IM_DOT, 2, -1);

    // reload straight from DONE without reset
    load(IM_LINE, -1);
    chk("reload busy", 64'(bus.busy), 64'd1);
    chk("reload done", 64'(bus.done), 64'd0);
    chk("reload iter_clr", 64'(bus.iter_count), 64'd0);
    wait_done(n);
    chk("reload finished", 64'(n < 2000), 64'd1);
    chk("reload iter", 64'(bus.iter_count), 64'd1);
    read_img(v);
    chk("reload image", v, IM_LINE);

    // abort during PASS2
    do_reset();
    load(IM_DOT, -1);
    repeat (NN + 10) @(negedge clk);
    chk("mid busy", 64'(bus.busy), 64'd1);
    bus.rd_addr = 6'd27;
    rst_n = 1'b0;
    #1;
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort done", 64'(bus.done), 64'd0);
    chk("abort iter", 64'(bus.iter_count), 64'd0);
    chk("abort rd", 64'(bus.rd_data), 64'd0);
    run("rst_reload", IM_DOT, IM_DOT, 1, -1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
